// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: single-character run/stop/clear decoder with echo/NAK reply handshake
module uart_cmd_ctrl #(
    parameter logic [7:0] CMD_RUN    = 8'h72,
    parameter logic [7:0] CMD_STOP   = 8'h73,
    parameter logic [7:0] CMD_CLEAR  = 8'h63,
    parameter logic [7:0] NAK_CHAR   = 8'h3F,
    parameter int         TX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_done,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt,
    output logic       o_tx_err
);
    localparam int CW = $clog2(TX_TIMEOUT);
    typedef enum logic [1:0] {IDLE, DECODE, SEND, WAIT_DONE} state_t;
    state_t state;
    logic [7:0] cmd_reg;
    logic [CW-1:0] tmo;
    logic is_run, is_stop, is_clr;
    logic [7:0] drop_inc;
    // Clearing bit 5 maps the lowercase command letter onto its uppercase twin
    assign is_run   = cmd_reg == CMD_RUN   || cmd_reg == (CMD_RUN   & 8'hDF);
    assign is_stop  = cmd_reg == CMD_STOP  || cmd_reg == (CMD_STOP  & 8'hDF);
    assign is_clr   = cmd_reg == CMD_CLEAR || cmd_reg == (CMD_CLEAR & 8'hDF);
    assign drop_inc = o_drop_cnt == 8'hFF ? o_drop_cnt : o_drop_cnt + 8'd1;
    assign o_busy   = state != IDLE;
    // Command FSM; a CLEAR decode is written after the drop increment so it wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_reg    <= 8'h00;
            tmo        <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
            o_run      <= 1'b0;
            o_clear    <= 1'b0;
            o_drop_cnt <= 8'h00;
            o_tx_err   <= 1'b0;
        end else begin
            if (state != IDLE && i_rx_done)
                o_drop_cnt <= drop_inc;
            case (state)
                IDLE: if (i_rx_done) begin
                    cmd_reg <= i_rx_data;
                    state   <= DECODE;
                end
                DECODE: begin
                    if (is_run)
                        o_run <= 1'b1;
                    if (is_stop)
                        o_run <= 1'b0;
                    if (is_clr) begin
                        o_clear    <= 1'b1;
                        o_drop_cnt <= 8'h00;
                        o_tx_err   <= 1'b0;
                    end
                    o_tx_data  <= (is_run || is_stop || is_clr) ? cmd_reg : NAK_CHAR;
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    o_tx_start <= 1'b0;
                    o_clear    <= 1'b0;
                    tmo        <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_tx_done)
                        state <= IDLE;
                    else if (tmo == CW'(TX_TIMEOUT - 1)) begin
                        o_tx_err <= 1'b1;
                        state    <= IDLE;
                    end else
                        tmo <= tmo + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
